systolic_tile_sched: RTL and testbench
======================================

Name: systolic_tile_sched

Overview:
Sequencer for the N1xN2 systolic array computing C = A x B for MxM matrices, one output tile at a time.
- Feed side: on start, walks all (M/N1)*(M/N2) output tiles back-to-back. Issues A/B bank read addresses and a per-tile init pulse.
- Drain side: independently tracks valid_D per array row and produces result-memory write addresses. Pulses done after the last tile drains.
- Placement: between the operand banks / result memory and the systolic array; sole owner of array sequencing.

Parameters:
- D_W_ACC, 16, accumulator width; carried on D and passed through to wr_data.
- N1, 4, array rows; must divide M.
- N2, 4, array columns; must divide M.
- M, 8, matrix dimension; power of two, M >= N1, M >= N2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin job; sampled in IDLE only
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, job complete
- rd_en  out  1  operand read strobe, both banks
- rd_addr_A  out  clog2(M*M/N1)  A bank address
- rd_addr_B  out  clog2(M*M/N2)  B bank address
- init_out  out  1  tile-start pulse to the array init shift chain
- valid_D  in  N1  per-row result valid from the array
- D  in  N1*D_W_ACC  per-row results, row i at bits [i*D_W_ACC +: D_W_ACC]
- wr_en  out  N1  per-row result-memory write enable
- wr_addr  out  N1*clog2(M*M)  per-row flat address (row*M+col), row i in slice i
- wr_data  out  N1*D_W_ACC  registered copy of D
- err  out  1  sticky; set when valid_D arrives with no tile outstanding

Behaviour:
- Reset: all outputs 0. FSM to IDLE. All counters 0. err cleared.
- Derived constants:
  - T = (M/N1)*(M/N2).
  - Tile t is indexed as sa = t / (M/N2), sb = t % (M/N2).
- FSM states: IDLE, FEED, FLUSH.
- IDLE
  - start=1 -> FEED next cycle; busy=1 from that cycle.
  - start=0 -> remain in IDLE.
- FEED
  - k counts 0..M-1 per tile. Feed tile index ft counts 0..T-1.
  - Every FEED cycle: rd_en=1, rd_addr_A = sa*M + k, rd_addr_B = sb*M + k.
  - init_out=1 exactly when k==0.
  - No bubble between tiles.
  - After k==M-1 with ft==T-1 -> FLUSH.
  - Total FEED length is T*M cycles.
- FLUSH
  - rd_en=0, init_out=0.
  - Stay until the drain tile index dt reaches T. Then done=1 for one cycle, busy=0, -> IDLE.
- Drain (runs in parallel with FEED and FLUSH)
  - Per-row counter c_i counts 0..N2-1. Drain tile index dt applies to all rows.
  - On valid_D[i]=1 with dt<T, next cycle:
    - wr_en[i]=1
    - wr_data row i = D row i
    - wr_addr row i = (sa_d*N1+i)*M + sb_d*N2 + (N2-1-c_i), with (sa_d, sb_d) derived from dt
    - then c_i increments.
  - Latency is 1 cycle, valid_D to wr_en.
  - A row whose c_i reached N2 holds at N2 until all rows reach N2. Then all c_i clear and dt increments, in the same cycle.
  - If the same-cycle valid_D for a row arrives then, it belongs to the new dt.
  - valid_D while dt==T or in IDLE: err sets sticky, no write issued.
- start during FEED/FLUSH: ignored.
- rst mid-job: immediate return to IDLE. No done pulse. Pending writes dropped.
- Address arithmetic is exact. No wrap occurs within a job; counters are sized exactly by clog2.

Optional Feature:
- Macro: SCHED_PERF_EN.
- Defined:
  - Adds output port cycle_cnt, 32 bits.
  - Cleared on accepted start; increments every cycle busy=1; holds after done.
  - Reset to 0; saturates at 2^32-1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Sequence, M=8, N1=N2=4, T=4: single start -> 32 FEED cycles. rd_addr_A = 0..7, 0..7, 8..15, 8..15. rd_addr_B = 0..7, 8..15, 0..7, 8..15. init_out high on FEED cycles 0, 8, 16, 24.
- Drain mapping: model array drives valid_D[2] four times for tile 0 -> wr_addr row2 = 19, 18, 17, 16 (row 2, cols 3..0), each one cycle after valid.
- Completion: all 4 rows x 4 valids x 4 tiles -> 64 writes. done pulses once, 1 cycle after the last tile's row completion. busy falls in the same cycle. Addresses 0..63 each written exactly once.
- Start while busy at FEED cycle 5 -> ignored, address sequence unchanged. Spurious valid_D[0] in IDLE -> err=1, wr_en=0. err stays 1 until rst.
- rst asserted at FEED cycle 12 -> next cycle busy=0, rd_en=0, all wr_en=0, no done. A new start restarts from rd_addr_A=0.
- SCHED_PERF_EN defined: job with final valids at cycle 40 after start -> cycle_cnt equals number of busy cycles. It is reset to 0 by the next accepted start.

Source files
------------

// File: rtl/systolic_tile_sched.sv
// Tile sequencer for an N1xN2 systolic array computing C = A x B on MxM matrices.
// Defining SCHED_PERF_EN adds the 32-bit busy-cycle counter output cycle_cnt.

module systolic_tile_sched #(
    parameter int D_W_ACC = 16,
    parameter int N1      = 4,
    parameter int N2      = 4,
    parameter int M       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [$clog2(M*M/N1)-1:0] rd_addr_A,
    output logic [$clog2(M*M/N2)-1:0] rd_addr_B,
    output logic                      init_out,
    input  logic [N1-1:0]             valid_D,
    input  logic [N1*D_W_ACC-1:0]     D,
    output logic [N1-1:0]             wr_en,
    output logic [N1*$clog2(M*M)-1:0] wr_addr,
    output logic [N1*D_W_ACC-1:0]     wr_data,
    output logic                      err
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]               cycle_cnt
`endif
);

    localparam int MA   = M / N1;
    localparam int NB   = M / N2;
    localparam int T    = MA * NB;
    localparam int AW_A = $clog2(M*M/N1);
    localparam int AW_B = $clog2(M*M/N2);
    localparam int AW_W = $clog2(M*M);
    localparam int KW   = (M  > 1) ? $clog2(M)  : 1;
    localparam int SAW  = (MA > 1) ? $clog2(MA) : 1;
    localparam int SBW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int DTW  = $clog2(T+1);
    localparam int CW   = $clog2(N2+1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [SAW-1:0]       fsa_q, fsa_d, dsa_q, dsa_d, e_sa;
    logic [SBW-1:0]       fsb_q, fsb_d, dsb_q, dsb_d, e_sb;
    logic [DTW-1:0]       dt_q, dt_d, e_dt;
    logic [CW-1:0]        c_q [N1];
    logic [CW-1:0]        c_d [N1];
    logic [CW-1:0]        e_c [N1];
    logic [AW_W-1:0]      waddr_d [N1];
    logic [N1-1:0]        acc;
    logic                 all_full;
    logic                 live;
    logic                 accept_start;
    logic                 feed_last;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [N1-1:0]        wr_en_q;
    logic [N1*AW_W-1:0]   wr_addr_q;
    logic [N1*D_W_ACC-1:0] wr_data_q;

    assign accept_start = (state_q == IDLE) && start;
    assign feed_last    = (k_q == KW'(M-1)) && (fsa_q == SAW'(MA-1)) && (fsb_q == SBW'(NB-1));

    assign busy      = (state_q != IDLE);
    assign rd_en     = (state_q == FEED);
    assign init_out  = rd_en && (k_q == '0);
    assign rd_addr_A = rd_en ? AW_A'(int'(fsa_q) * M + int'(k_q)) : '0;
    assign rd_addr_B = rd_en ? AW_B'(int'(fsb_q) * M + int'(k_q)) : '0;
    assign done      = done_q;
    assign err       = err_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = FEED;
            FEED:  if (feed_last) state_d = FLUSH;
            FLUSH: begin
                // Leave as soon as the drain index is about to reach T.
                if (dt_d == DTW'(T)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d   = k_q;
        fsa_d = fsa_q;
        fsb_d = fsb_q;
        if (accept_start) begin
            k_d   = '0;
            fsa_d = '0;
            fsb_d = '0;
        end else if (state_q == FEED) begin
            if (k_q == KW'(M-1)) begin
                k_d = '0;
                if (fsb_q == SBW'(NB-1)) begin
                    fsb_d = '0;
                    fsa_d = (fsa_q == SAW'(MA-1)) ? '0 : fsa_q + SAW'(1);
                end else begin
                    fsb_d = fsb_q + SBW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    // A row that has all N2 results waits; once every row is full the tile retires
    // and any valid_D in that same cycle already belongs to the next tile.
    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < N1; i++) begin
            if (c_q[i] != CW'(N2)) all_full = 1'b0;
        end

        e_dt = dt_q;
        e_sa = dsa_q;
        e_sb = dsb_q;
        if (all_full) begin
            e_dt = dt_q + DTW'(1);
            if (dsb_q == SBW'(NB-1)) begin
                e_sb = '0;
                e_sa = (dsa_q == SAW'(MA-1)) ? '0 : dsa_q + SAW'(1);
            end else begin
                e_sb = dsb_q + SBW'(1);
            end
        end

        live  = busy && (e_dt != DTW'(T));
        err_d = err_q | ((|valid_D) && !live);

        for (int i = 0; i < N1; i++) begin
            e_c[i]     = all_full ? '0 : c_q[i];
            acc[i]     = valid_D[i] && live && (e_c[i] < CW'(N2));
            c_d[i]     = e_c[i] + CW'(acc[i]);
            waddr_d[i] = AW_W'((int'(e_sa) * N1 + i) * M + int'(e_sb) * N2
                               + (N2 - 1 - int'(e_c[i])));
        end

        dt_d  = e_dt;
        dsa_d = e_sa;
        dsb_d = e_sb;
        if (accept_start) begin
            dt_d  = '0;
            dsa_d = '0;
            dsb_d = '0;
            for (int i = 0; i < N1; i++) c_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            fsa_q     <= '0;
            fsb_q     <= '0;
            dt_q      <= '0;
            dsa_q     <= '0;
            dsb_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < N1; i++) c_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            fsa_q     <= fsa_d;
            fsb_q     <= fsb_d;
            dt_q      <= dt_d;
            dsa_q     <= dsa_d;
            dsb_q     <= dsb_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= acc;
            wr_data_q <= D;
            for (int i = 0; i < N1; i++) begin
                c_q[i] <= c_d[i];
                if (acc[i]) wr_addr_q[i*AW_W +: AW_W] <= waddr_d[i];
            end
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)               cnt_q <= '0;
        else if (accept_start) cnt_q <= '0;
        else if (busy)         cnt_q <= sat_inc32(cnt_q);
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Self-checking bench for systolic_tile_sched: random drain schedules against a tile-level model.
// Exercises the SCHED_PERF_EN counter when that macro is defined.

module tb_systolic_tile_sched;

    localparam int D_W_ACC = 16;
    localparam int N1      = 4;
    localparam int N2      = 4;
    localparam int M       = 8;
    localparam int MA      = M / N1;
    localparam int NB      = M / N2;
    localparam int T       = MA * NB;
    localparam int AW_A    = $clog2(M*M/N1);
    localparam int AW_B    = $clog2(M*M/N2);
    localparam int AW_W    = $clog2(M*M);
    localparam int NCYC    = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    busy, done, rd_en, init_out, err;
    logic [AW_A-1:0]         rd_addr_A;
    logic [AW_B-1:0]         rd_addr_B;
    logic [N1-1:0]           valid_D;
    logic [N1*D_W_ACC-1:0]   D;
    logic [N1-1:0]           wr_en;
    logic [N1*AW_W-1:0]      wr_addr;
    logic [N1*D_W_ACC-1:0]   wr_data;
`ifdef SCHED_PERF_EN
    logic [31:0]             cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Stimulus schedule and expected results, indexed by cycle after the accepting edge.
    logic [N1-1:0]        sched_v   [NCYC];
    logic [D_W_ACC-1:0]   sched_d   [NCYC][N1];
    logic [N1-1:0]        exp_wen   [NCYC];
    int                   exp_waddr [NCYC][N1];
    logic [D_W_ACC-1:0]   exp_wdata [NCYC][N1];
    int                   exp_done;
    int                   row2_valid_cyc [N2];

    logic                 obs_busy  [NCYC];
    logic                 obs_done  [NCYC];
    logic                 obs_rden  [NCYC];
    logic                 obs_init  [NCYC];
    logic                 obs_err   [NCYC];
    logic [AW_A-1:0]      obs_A     [NCYC];
    logic [AW_B-1:0]      obs_B     [NCYC];
    logic [N1-1:0]        obs_wen   [NCYC];
    logic [AW_W-1:0]      obs_waddr [NCYC][N1];
    logic [D_W_ACC-1:0]   obs_wdata [NCYC][N1];
    logic [31:0]          obs_cnt   [NCYC];

    systolic_tile_sched #(.D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_A (rd_addr_A),
        .rd_addr_B (rd_addr_B),
        .init_out  (init_out),
        .valid_D   (valid_D),
        .D         (D),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err)
`ifdef SCHED_PERF_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random model array: each row returns N2 results per tile, a tile never begins
    // before the previous one has fully drained, and results trail the feed of that tile.
    task automatic build_schedule();
        int s, o, b, cyc, tv, prev_v;
        for (int c = 0; c < NCYC; c++) begin
            sched_v[c] = '0;
            exp_wen[c] = '0;
            for (int i = 0; i < N1; i++) begin
                sched_d[c][i]   = D_W_ACC'($urandom);
                exp_waddr[c][i] = 0;
                exp_wdata[c][i] = '0;
            end
        end
        prev_v = -1;
        for (int t = 0; t < T; t++) begin
            s = t * M + 6 + int'($urandom_range(0, 2));
            if (t > 0 && prev_v + 1 + int'($urandom_range(0, 1)) > s)
                s = prev_v + 1 + int'($urandom_range(0, 1));
            if (t > 0 && s <= prev_v) s = prev_v + 1;
            tv = prev_v;
            for (int i = 0; i < N1; i++) begin
                o = int'($urandom_range(0, 2));
                b = int'($urandom_range(1, N2));
                for (int j = 0; j < N2; j++) begin
                    cyc = s + o + j + ((j >= b) ? 1 : 0);
                    sched_v[cyc][i]       = 1'b1;
                    exp_wen[cyc+1][i]     = 1'b1;
                    exp_waddr[cyc+1][i]   = ((t / NB) * N1 + i) * M + (t % NB) * N2 + (N2 - 1 - j);
                    exp_wdata[cyc+1][i]   = sched_d[cyc][i];
                    if (t == 0 && i == 2) row2_valid_cyc[j] = cyc;
                    if (cyc > tv) tv = cyc;
                end
            end
            prev_v = tv;
        end
        exp_done = prev_v + 2;
    endtask

    // Runs one job from start, capturing every output once per cycle (no checking here).
    task automatic run_job(input int glitch_at, input int rst_at);
        int nrun;
        build_schedule();
        nrun  = (rst_at >= 0) ? rst_at + 2 : NCYC;
        start = 1'b1;
        for (int f = 0; f < NCYC; f++) begin
            obs_busy[f] = 1'b0; obs_done[f] = 1'b0; obs_rden[f] = 1'b0;
            obs_init[f] = 1'b0; obs_err[f] = 1'b0; obs_wen[f] = '0;
        end
        for (int f = 0; f < nrun; f++) begin
            tick();
            obs_busy[f] = busy;
            obs_done[f] = done;
            obs_rden[f] = rd_en;
            obs_init[f] = init_out;
            obs_err[f]  = err;
            obs_A[f]    = rd_addr_A;
            obs_B[f]    = rd_addr_B;
            obs_wen[f]  = wr_en;
            for (int i = 0; i < N1; i++) begin
                obs_waddr[f][i] = wr_addr[i*AW_W +: AW_W];
                obs_wdata[f][i] = wr_data[i*D_W_ACC +: D_W_ACC];
            end
`ifdef SCHED_PERF_EN
            obs_cnt[f] = cycle_cnt;
`else
            obs_cnt[f] = 32'd0;
`endif
            start = (f == glitch_at);
            rst   = (f == rst_at);
            if (rst_at >= 0 && f > rst_at) begin
                valid_D = '0;
            end else begin
                valid_D = sched_v[f];
                for (int i = 0; i < N1; i++) D[i*D_W_ACC +: D_W_ACC] = sched_d[f][i];
            end
        end
        start   = 1'b0;
        rst     = 1'b0;
        valid_D = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; valid_D = '0; D = '0;
        tick(); tick(); tick();
        checks++;
        if ({busy, done, rd_en, init_out, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy/done/rd_en/init/err=%b exp=00000",
                     {busy, done, rd_en, init_out, err});
        end
        checks++;
        if (rd_addr_A !== '0 || rd_addr_B !== '0 || wr_en !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_data got A=%0d B=%0d wr_en=%b wr_addr=%h wr_data=%h exp all 0",
                     rd_addr_A, rd_addr_B, wr_en, wr_addr, wr_data);
        end
`ifdef SCHED_PERF_EN
        checks++;
        if (cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sequence();
        int t, k;
        run_job(-1, -1);
        for (int f = 0; f < T * M; f++) begin
            t = f / M;
            k = f % M;
            checks++;
            if (obs_busy[f] !== 1'b1 || obs_rden[f] !== 1'b1 || obs_init[f] !== (k == 0)) begin
                errors++;
                $display("FAIL feed_ctrl f=%0d got busy=%b rd_en=%b init=%b exp 1 1 %b",
                         f, obs_busy[f], obs_rden[f], obs_init[f], (k == 0));
            end
            checks++;
            if (int'(obs_A[f]) !== (t / NB) * M + k || int'(obs_B[f]) !== (t % NB) * M + k) begin
                errors++;
                $display("FAIL feed_addr f=%0d got A=%0d B=%0d exp A=%0d B=%0d",
                         f, obs_A[f], obs_B[f], (t / NB) * M + k, (t % NB) * M + k);
            end
        end
        for (int f = T * M; f < exp_done; f++) begin
            checks++;
            if (obs_busy[f] !== 1'b1 || obs_rden[f] !== 1'b0 || obs_init[f] !== 1'b0) begin
                errors++;
                $display("FAIL flush_ctrl f=%0d got busy=%b rd_en=%b init=%b exp 1 0 0",
                         f, obs_busy[f], obs_rden[f], obs_init[f]);
            end
        end
    endtask

    task automatic test_drain_mapping();
        int exp_map [N2];
        int n;
        exp_map = '{19, 18, 17, 16};
        run_job(-1, -1);
        n = 0;
        for (int f = 0; f < NCYC; f++) begin
            if (obs_wen[f][2] === 1'b1 && n < N2) begin
                checks++;
                if (int'(obs_waddr[f][2]) !== exp_map[n] || f !== row2_valid_cyc[n] + 1) begin
                    errors++;
                    $display("FAIL drain_row2 n=%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d",
                             n, obs_waddr[f][2], f, exp_map[n], row2_valid_cyc[n] + 1);
                end
                n++;
            end
        end
        checks++;
        if (n !== N2) begin
            errors++;
            $display("FAIL drain_row2_count got=%0d exp=%0d", n, N2);
        end
    endtask

    task automatic test_completion();
        int hits [M*M];
        int ndone;
        for (int a = 0; a < M * M; a++) hits[a] = 0;
        run_job(-1, -1);
        ndone = 0;
        for (int f = 0; f < NCYC; f++) begin
            checks++;
            if (obs_wen[f] !== exp_wen[f]) begin
                errors++;
                $display("FAIL wr_en f=%0d got=%b exp=%b", f, obs_wen[f], exp_wen[f]);
            end
            for (int i = 0; i < N1; i++) begin
                if (obs_wen[f][i] === 1'b1) hits[int'(obs_waddr[f][i])]++;
                if (exp_wen[f][i]) begin
                    checks++;
                    if (int'(obs_waddr[f][i]) !== exp_waddr[f][i] || obs_wdata[f][i] !== exp_wdata[f][i]) begin
                        errors++;
                        $display("FAIL write f=%0d row=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                 f, i, obs_waddr[f][i], obs_wdata[f][i], exp_waddr[f][i], exp_wdata[f][i]);
                    end
                end
            end
            checks++;
            if (obs_done[f] !== (f == exp_done) || obs_busy[f] !== (f < exp_done)) begin
                errors++;
                $display("FAIL done_busy f=%0d got done=%b busy=%b exp done=%b busy=%b",
                         f, obs_done[f], obs_busy[f], (f == exp_done), (f < exp_done));
            end
            if (obs_done[f] === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL done_count got=%0d exp=1", ndone);
        end
        for (int a = 0; a < M * M; a++) begin
            checks++;
            if (hits[a] !== 1) begin
                errors++;
                $display("FAIL coverage addr=%0d got writes=%0d exp=1", a, hits[a]);
            end
        end
        checks++;
        if (obs_err[NCYC-1] !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got=%b exp=0", obs_err[NCYC-1]);
        end
`ifdef SCHED_PERF_EN
        checks++;
        if (obs_cnt[0] !== 32'd0 || obs_cnt[NCYC-1] !== 32'(exp_done)) begin
            errors++;
            $display("FAIL cycle_cnt got first=%0d final=%0d exp first=0 final=%0d",
                     obs_cnt[0], obs_cnt[NCYC-1], exp_done);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int t, k;
        run_job(5, -1);
        for (int f = 0; f < T * M; f++) begin
            t = f / M;
            k = f % M;
            checks++;
            if (int'(obs_A[f]) !== (t / NB) * M + k || int'(obs_B[f]) !== (t % NB) * M + k) begin
                errors++;
                $display("FAIL glitch_addr f=%0d got A=%0d B=%0d exp A=%0d B=%0d",
                         f, obs_A[f], obs_B[f], (t / NB) * M + k, (t % NB) * M + k);
            end
        end
        checks++;
        if (obs_done[exp_done] !== 1'b1 || obs_busy[exp_done] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_done f=%0d got done=%b busy=%b exp done=1 busy=0",
                     exp_done, obs_done[exp_done], obs_busy[exp_done]);
        end
    endtask

    task automatic test_err();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before got=%b exp=0", err);
        end
        valid_D = N1'(1);
        tick();
        valid_D = '0;
        checks++;
        if (err !== 1'b1 || wr_en !== '0) begin
            errors++;
            $display("FAIL err_set got err=%b wr_en=%b exp err=1 wr_en=0", err, wr_en);
        end
        tick(); tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
        tick();
    endtask

    task automatic test_rst_midjob();
        int ndone;
        run_job(-1, 12);
        checks++;
        if (obs_busy[13] !== 1'b0 || obs_rden[13] !== 1'b0 || obs_wen[13] !== '0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b rd_en=%b wr_en=%b exp 0 0 0",
                     obs_busy[13], obs_rden[13], obs_wen[13]);
        end
        ndone = 0;
        for (int f = 0; f < 14; f++) if (obs_done[f] === 1'b1) ndone++;
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL rst_no_done got=%0d exp=0", ndone);
        end
        run_job(-1, -1);
        checks++;
        if (obs_A[0] !== '0 || obs_B[0] !== '0 || obs_init[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart got A=%0d B=%0d init=%b exp 0 0 1", obs_A[0], obs_B[0], obs_init[0]);
        end
        checks++;
        if (obs_done[exp_done] !== 1'b1) begin
            errors++;
            $display("FAIL restart_done f=%0d got=%b exp=1", exp_done, obs_done[exp_done]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid_D = '0; D = '0;
        test_reset();
        test_sequence();
        test_drain_mapping();
        test_completion();
        test_start_ignored();
        test_err();
        test_rst_midjob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
